clkmgr_fam_seq: RTL and testbench
=================================

CLKMGR_FAM_SEQ -- requirements
Module: clkmgr_fam_seq

Interface
REQ-001 SHALL have parameter NumClocks, default 4: number of clocks in the family; legal range 1..32.
REQ-002 SHALL have parameter StaggerCycles, default 2: cycles between successive enable/disable steps; minimum 1.
REQ-003 SHALL have parameter TimeoutCycles, default 256: maximum wait-for-status cycles before an error pulse; minimum 1.
REQ-004 clk_i  input  1  clock; rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 req_en_i  input  1  family on-request from power manager; level, synchronous to clk_i.
REQ-006 status_i  input  1  filtered family status: 1 = all clocks on, 0 = all off, held otherwise.
REQ-007 clk_en_o  output  NumClocks  per-clock gate enables, registered.
REQ-008 ack_o  output  1  achieved-state acknowledge, registered.
REQ-009 busy_o  output  1  high in any state other than IDLE and ON.
REQ-010 timeout_o  output  1  one-cycle pulse on wait timeout.
REQ-011 fsm_err_o  output  1  sticky illegal-state error.

Function
REQ-012 FSM states: IDLE, RAMP_UP, WAIT_ON, ON, RAMP_DN, WAIT_OFF.
REQ-013 req_en_i is sampled only in IDLE and ON; changes in other states are ignored until the sequence completes.
REQ-014 IDLE with req_en_i=1 at edge t: at t+1 state=RAMP_UP, clk_en_o[0]=1, step index=0, stagger counter cleared.
REQ-015 RAMP_UP: bit k of clk_en_o is set exactly k*StaggerCycles cycles after bit 0; set bits stay set.
REQ-016 RAMP_UP: one cycle after bit NumClocks-1 is set, state=WAIT_ON and the timeout counter is cleared.
REQ-017 WAIT_ON with status_i=1: next cycle state=ON and ack_o=1.
REQ-018 ON with req_en_i=0: next cycle state=RAMP_DN and clk_en_o[NumClocks-1]=0.
REQ-019 RAMP_DN: bits clear in descending index order, one per StaggerCycles; one cycle after bit 0 clears, state=WAIT_OFF with the timeout counter cleared.
REQ-020 WAIT_OFF with status_i=0: next cycle state=IDLE and ack_o=0.
REQ-021 ack_o stays 1 from ON entry through RAMP_DN and WAIT_OFF; it changes only on the WAIT_ON->ON and WAIT_OFF->IDLE transitions.
REQ-022 Timeout: in WAIT_ON/WAIT_OFF, when the counter reaches TimeoutCycles without the awaited status, timeout_o=1 for one cycle, the counter restarts from 0, and the state is unchanged.
REQ-023 If status reaches the awaited value in the same cycle as the timeout, the state transition takes place and timeout_o stays 0.
REQ-024 NumClocks=1: the ramp degenerates to a single step, after which the FSM moves to the wait state on the next cycle.
REQ-025 Counter widths: stagger is $clog2(StaggerCycles+1), timeout is $clog2(TimeoutCycles+1), and index is $clog2(NumClocks) (minimum 1); counters do not wrap.
REQ-026 Illegal state encoding: next cycle state=IDLE, clk_en_o=0, ack_o=0, and fsm_err_o=1 until reset.

Reset
REQ-027 While rst_ni=0: state=IDLE, clk_en_o=0, ack_o=0, busy_o=0, timeout_o=0, fsm_err_o=0, and all counters=0.
REQ-028 Reset asserted mid-sequence immediately forces all outputs to their reset values; after release the FSM restarts from IDLE.

Structure
REQ-029 The fam_seq_state_e sparse-encoded state typedef and its width constant SHALL reside in clkmgr_pkg.
REQ-030 The state register SHALL be one prim_sparse_fsm_flop instance; all other logic is flat in this module.

Verification (NumClocks=4, StaggerCycles=2, TimeoutCycles=8)
REQ-031 req_en_i 0->1 at t, then status_i=1 at t+10 -> clk_en_o bits 0..3 set at t+1/3/5/7; WAIT_ON at t+8; ack_o=1 at t+11.
REQ-032 From ON, req_en_i=0 at u, then status_i=0 at u+10 -> bits 3..0 clear at u+1/3/5/7; ack_o=0 at u+11.
REQ-033 status_i held 0 in WAIT_ON -> timeout_o pulses every 8 cycles; ack_o stays 0; state stays WAIT_ON.
REQ-034 req_en_i pulsed 1 for 2 cycles from IDLE -> full ramp up, then ack_o=1, then ramp down begins on the next ON cycle.
REQ-035 rst_ni asserted with clk_en_o=4'b0011 -> clk_en_o=0 and ack_o=0 immediately; after release, IDLE is held while req_en_i=0.
REQ-036 Force an illegal state encoding -> fsm_err_o=1 sticky, clk_en_o=0, and the FSM returns to IDLE.

Source files
------------

// File: rtl/clkmgr_pkg.sv
// Shared clock-manager types: sparse state encoding for the family sequencer.
package clkmgr_pkg;

  localparam int FamSeqStateWidth = 6;

  // Codes are spread apart so a single upset cannot land on another legal state.
  typedef enum logic [FamSeqStateWidth-1:0] {
    IDLE     = 6'b101100,
    RAMP_UP  = 6'b000111,
    WAIT_ON  = 6'b011010,
    ON       = 6'b110001,
    RAMP_DN  = 6'b111110,
    WAIT_OFF = 6'b010101
  } fam_seq_state_e;

endpackage

// File: rtl/prim_sparse_fsm_flop.sv
// State register for sparse-encoded FSMs; kept as its own cell so the encoding survives synthesis.
module prim_sparse_fsm_flop #(
  parameter int                Width      = 1,
  parameter logic [Width-1:0]  ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] state_i,
  output logic [Width-1:0] state_o
);

  logic [Width-1:0] state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ResetValue;
    end else begin
      state_q <= state_i;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/clkmgr_fam_seq.sv
// Clock family sequencer: staggers gate enables up/down, waits for the family status
// to confirm, and flags wait timeouts and corrupted state encodings.
module clkmgr_fam_seq
  import clkmgr_pkg::*;
#(
  parameter int NumClocks     = 4,
  parameter int StaggerCycles = 2,
  parameter int TimeoutCycles = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_en_i,
  input  logic                 status_i,
  output logic [NumClocks-1:0] clk_en_o,
  output logic                 ack_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic                 fsm_err_o
);

  localparam int StaggerW = $clog2(StaggerCycles + 1);
  localparam int TimeoutW = $clog2(TimeoutCycles + 1);
  localparam int IdxW     = (NumClocks > 1) ? $clog2(NumClocks) : 1;

  localparam logic [IdxW-1:0]     LastIdx     = IdxW'(NumClocks - 1);
  localparam logic [StaggerW-1:0] StaggerLast = StaggerW'(StaggerCycles - 1);
  localparam logic [TimeoutW-1:0] TimeoutMax  = TimeoutW'(TimeoutCycles);

  fam_seq_state_e               state_q, state_d;
  logic [FamSeqStateWidth-1:0]  state_raw;
  logic [NumClocks-1:0]         clk_en_q, clk_en_d;
  logic                         ack_q, ack_d;
  logic                         timeout_q, timeout_d;
  logic                         err_q, err_d;
  logic [StaggerW-1:0]          stagger_q, stagger_d;
  logic [TimeoutW-1:0]          tmo_q, tmo_d, tmo_inc;
  logic [IdxW-1:0]              idx_q, idx_d, idx_up, idx_dn;

  prim_sparse_fsm_flop #(
    .Width      (FamSeqStateWidth),
    .ResetValue (FamSeqStateWidth'(IDLE))
  ) u_state_flop (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .state_i (state_d),
    .state_o (state_raw)
  );

  assign state_q = fam_seq_state_e'(state_raw);
  assign tmo_inc = tmo_q + 1'b1;
  assign idx_up  = idx_q + 1'b1;
  assign idx_dn  = idx_q - 1'b1;

  always_comb begin
    state_d   = state_q;
    clk_en_d  = clk_en_q;
    ack_d     = ack_q;
    timeout_d = 1'b0;
    err_d     = err_q;
    stagger_d = stagger_q;
    tmo_d     = tmo_q;
    idx_d     = idx_q;

    unique case (state_q)
      IDLE: begin
        if (req_en_i) begin
          state_d     = RAMP_UP;
          clk_en_d    = '0;
          clk_en_d[0] = 1'b1;
          idx_d       = '0;
          stagger_d   = '0;
        end
      end

      RAMP_UP: begin
        if (idx_q == LastIdx) begin
          state_d   = WAIT_ON;
          tmo_d     = '0;
          stagger_d = '0;
        end else if (stagger_q == StaggerLast) begin
          stagger_d        = '0;
          idx_d            = idx_up;
          clk_en_d[idx_up] = 1'b1;
        end else begin
          stagger_d = stagger_q + 1'b1;
        end
      end

      // Awaited status wins over a timeout landing in the same cycle.
      WAIT_ON: begin
        if (status_i) begin
          state_d = ON;
          ack_d   = 1'b1;
          tmo_d   = '0;
        end else if (tmo_inc == TimeoutMax) begin
          timeout_d = 1'b1;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      ON: begin
        if (!req_en_i) begin
          state_d                 = RAMP_DN;
          clk_en_d[NumClocks-1]   = 1'b0;
          idx_d                   = LastIdx;
          stagger_d               = '0;
        end
      end

      RAMP_DN: begin
        if (idx_q == '0) begin
          state_d   = WAIT_OFF;
          tmo_d     = '0;
          stagger_d = '0;
        end else if (stagger_q == StaggerLast) begin
          stagger_d        = '0;
          idx_d            = idx_dn;
          clk_en_d[idx_dn] = 1'b0;
        end else begin
          stagger_d = stagger_q + 1'b1;
        end
      end

      WAIT_OFF: begin
        if (!status_i) begin
          state_d = IDLE;
          ack_d   = 1'b0;
          tmo_d   = '0;
        end else if (tmo_inc == TimeoutMax) begin
          timeout_d = 1'b1;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      default: begin
        state_d   = IDLE;
        clk_en_d  = '0;
        ack_d     = 1'b0;
        err_d     = 1'b1;
        stagger_d = '0;
        tmo_d     = '0;
        idx_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_en_q  <= '0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      stagger_q <= '0;
      tmo_q     <= '0;
      idx_q     <= '0;
    end else begin
      clk_en_q  <= clk_en_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      stagger_q <= stagger_d;
      tmo_q     <= tmo_d;
      idx_q     <= idx_d;
    end
  end

  assign clk_en_o  = clk_en_q;
  assign ack_o     = ack_q;
  assign timeout_o = timeout_q;
  assign fsm_err_o = err_q;
  assign busy_o    = (state_q != IDLE) && (state_q != ON);

endmodule

// File: tb/tb_clkmgr_fam_seq.sv
// Directed bench for the clock family sequencer with hand-computed cycle timings.
module tb_clkmgr_fam_seq;
  import clkmgr_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       req_en;
  logic       status;
  logic [3:0] clk_en;
  logic       ack;
  logic       busy;
  logic       timeout;
  logic       fsm_err;

  int checks = 0;
  int fails  = 0;

  clkmgr_fam_seq #(
    .NumClocks     (4),
    .StaggerCycles (2),
    .TimeoutCycles (8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_en_i  (req_en),
    .status_i  (status),
    .clk_en_o  (clk_en),
    .ack_o     (ack),
    .busy_o    (busy),
    .timeout_o (timeout),
    .fsm_err_o (fsm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just past the edge, so inputs change away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    req_en = 1'b0;
    status = 1'b0;
    step();
    step();
    checks++;
    if (clk_en !== 4'h0 || ack !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0 || fsm_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_values: clk_en=%b ack=%b busy=%b timeout=%b err=%b, required all zero",
               clk_en, ack, busy, timeout, fsm_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (dut.state_q !== IDLE || clk_en !== 4'h0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_release_idle: state=%b clk_en=%b busy=%b, required IDLE 0000 0",
               dut.state_q, clk_en, busy);
    end
  endtask

  task automatic test_ramp_up();
    logic [3:0]     exp_en [10] = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hf, 4'hf, 4'hf, 4'hf};
    fam_seq_state_e exp_st [10] = '{RAMP_UP, RAMP_UP, RAMP_UP, RAMP_UP, RAMP_UP, RAMP_UP,
                                    RAMP_UP, WAIT_ON, WAIT_ON, WAIT_ON};
    req_en = 1'b1;
    status = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (clk_en !== exp_en[k] || dut.state_q !== exp_st[k] || ack !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("[TB] FAIL ramp_up t+%0d: clk_en=%b state=%b ack=%b busy=%b, required clk_en=%b state=%b ack=0 busy=1",
                 k + 1, clk_en, dut.state_q, ack, busy, exp_en[k], exp_st[k]);
      end
    end
    status = 1'b1;
    step();
    checks++;
    if (ack !== 1'b1 || busy !== 1'b0 || clk_en !== 4'hf || dut.state_q !== ON) begin
      fails++;
      $display("[TB] FAIL ramp_up_ack t+11: ack=%b busy=%b clk_en=%b, required ack=1 busy=0 clk_en=1111",
               ack, busy, clk_en);
    end
    step();
    checks++;
    if (ack !== 1'b1 || busy !== 1'b0 || clk_en !== 4'hf) begin
      fails++;
      $display("[TB] FAIL on_hold: ack=%b busy=%b clk_en=%b, required ack=1 busy=0 clk_en=1111",
               ack, busy, clk_en);
    end
  endtask

  task automatic test_ramp_down();
    logic [3:0] exp_en [10] = '{4'h7, 4'h7, 4'h3, 4'h3, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    req_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (clk_en !== exp_en[k] || ack !== 1'b1 || busy !== 1'b1) begin
        fails++;
        $display("[TB] FAIL ramp_down u+%0d: clk_en=%b ack=%b busy=%b, required clk_en=%b ack=1 busy=1",
                 k + 1, clk_en, ack, busy, exp_en[k]);
      end
    end
    status = 1'b0;
    step();
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || clk_en !== 4'h0 || dut.state_q !== IDLE) begin
      fails++;
      $display("[TB] FAIL ramp_down_ack u+11: ack=%b busy=%b clk_en=%b, required ack=0 busy=0 clk_en=0000",
               ack, busy, clk_en);
    end
  endtask

  task automatic test_timeout();
    logic exp_t;
    req_en = 1'b1;
    status = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    for (int k = 9; k <= 31; k++) begin
      step();
      exp_t = (k == 16) || (k == 24);
      checks++;
      if (timeout !== exp_t || ack !== 1'b0 || busy !== 1'b1 || dut.state_q !== WAIT_ON) begin
        fails++;
        $display("[TB] FAIL wait_on_timeout t+%0d: timeout=%b ack=%b busy=%b state=%b, required timeout=%b ack=0 busy=1 WAIT_ON",
                 k, timeout, ack, busy, dut.state_q, exp_t);
      end
    end
    // Status arrives on the very cycle the counter would expire.
    status = 1'b1;
    step();
    checks++;
    if (timeout !== 1'b0 || ack !== 1'b1 || dut.state_q !== ON) begin
      fails++;
      $display("[TB] FAIL timeout_coincident: timeout=%b ack=%b state=%b, required timeout=0 ack=1 ON",
               timeout, ack, dut.state_q);
    end
    req_en = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      exp_t = (k == 16);
      checks++;
      if (timeout !== exp_t || ack !== 1'b1 || busy !== 1'b1) begin
        fails++;
        $display("[TB] FAIL wait_off_timeout u+%0d: timeout=%b ack=%b busy=%b, required timeout=%b ack=1 busy=1",
                 k, timeout, ack, busy, exp_t);
      end
    end
    status = 1'b0;
    step();
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wait_off_exit: ack=%b busy=%b timeout=%b, required 0 0 0", ack, busy, timeout);
    end
  endtask

  task automatic test_req_pulse();
    req_en = 1'b1;
    step();
    step();
    req_en = 1'b0;
    for (int k = 3; k <= 8; k++) step();
    checks++;
    if (clk_en !== 4'hf || busy !== 1'b1 || dut.state_q !== WAIT_ON) begin
      fails++;
      $display("[TB] FAIL pulse_ramp t+8: clk_en=%b busy=%b state=%b, required 1111 1 WAIT_ON",
               clk_en, busy, dut.state_q);
    end
    status = 1'b1;
    step();
    checks++;
    if (ack !== 1'b1 || busy !== 1'b0 || clk_en !== 4'hf) begin
      fails++;
      $display("[TB] FAIL pulse_on t+9: ack=%b busy=%b clk_en=%b, required 1 0 1111", ack, busy, clk_en);
    end
    step();
    checks++;
    if (clk_en !== 4'h7 || ack !== 1'b1 || busy !== 1'b1 || dut.state_q !== RAMP_DN) begin
      fails++;
      $display("[TB] FAIL pulse_ramp_dn t+10: clk_en=%b ack=%b busy=%b, required 0111 1 1", clk_en, ack, busy);
    end
    for (int k = 11; k <= 17; k++) step();
    status = 1'b0;
    step();
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || clk_en !== 4'h0) begin
      fails++;
      $display("[TB] FAIL pulse_done t+18: ack=%b busy=%b clk_en=%b, required 0 0 0000", ack, busy, clk_en);
    end
  endtask

  task automatic test_reset_mid();
    req_en = 1'b1;
    step();
    step();
    step();
    checks++;
    if (clk_en !== 4'h3) begin
      fails++;
      $display("[TB] FAIL mid_precondition: clk_en=%b, required 0011", clk_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (clk_en !== 4'h0 || ack !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_reset_async: clk_en=%b ack=%b busy=%b timeout=%b, required all zero",
               clk_en, ack, busy, timeout);
    end
    req_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (dut.state_q !== IDLE || clk_en !== 4'h0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_reset_idle: state=%b clk_en=%b busy=%b, required IDLE 0000 0",
               dut.state_q, clk_en, busy);
    end
  endtask

  task automatic test_illegal_state();
    req_en = 1'b1;
    status = 1'b1;
    for (int k = 0; k < 9; k++) step();
    checks++;
    if (ack !== 1'b1 || clk_en !== 4'hf || fsm_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL illegal_precondition: ack=%b clk_en=%b err=%b, required 1 1111 0", ack, clk_en, fsm_err);
    end
    req_en = 1'b0;
    force dut.u_state_flop.state_q = 6'b000000;
    step();
    release dut.u_state_flop.state_q;
    #0;
    checks++;
    if (fsm_err !== 1'b1 || clk_en !== 4'h0 || ack !== 1'b0) begin
      fails++;
      $display("[TB] FAIL illegal_recover: err=%b clk_en=%b ack=%b, required 1 0000 0", fsm_err, clk_en, ack);
    end
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (fsm_err !== 1'b1 || dut.state_q !== IDLE || busy !== 1'b0 || clk_en !== 4'h0) begin
      fails++;
      $display("[TB] FAIL illegal_sticky: err=%b state=%b busy=%b clk_en=%b, required 1 IDLE 0 0000",
               fsm_err, dut.state_q, busy, clk_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (fsm_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL illegal_reset_clear: err=%b, required 0", fsm_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_timeout();
    test_req_pulse();
    test_reset_mid();
    test_illegal_state();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
